// File: rtl/fpmul_arbiter.sv
// fpmul_arbiter: two-requester round-robin front end for one shared, pipelined FP multiplier.
// Latency: grant is combinational in cycle t, operands registered for t+1, result tag at t+1+MUL_LAT.
// Backpressure: READY drops under HOLD, reset or losing contention; results have no backpressure.
module fpmul_arbiter #(
  parameter int MUL_LAT = 3  // multiplier latency in cycles, 1..14
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_hold,
  input  logic        i_r0_valid,
  input  logic        i_r1_valid,
  input  logic [31:0] i_r0_a,
  input  logic [31:0] i_r0_b,
  input  logic [31:0] i_r1_a,
  input  logic [31:0] i_r1_b,
  output logic        o_r0_ready,
  output logic        o_r1_ready,
  output logic [31:0] o_mul_a,
  output logic [31:0] o_mul_b,
  input  logic [31:0] i_mul_z,
  output logic        o_res_valid,
  output logic        o_res_id,
  output logic [31:0] o_res_z,
  output logic [3:0]  o_inflight,
  output logic        o_idle
);

  // One tag stage per multiplier cycle plus the operand register stage.
  localparam int DEPTH = MUL_LAT + 1;

  logic             r_last;       // requester granted most recently
  logic [31:0]      r_mul_a;
  logic [31:0]      r_mul_b;
  logic [DEPTH-1:0] r_tag_vld;    // bit 0 is the youngest stage
  logic [DEPTH-1:0] r_tag_id;
  logic [3:0]       r_inflight;
  logic             r_idle;

  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_xfer;
  logic [3:0]       w_inflight_nxt;

  // Arbitration: a lone requester always wins; on contention the one not granted last wins.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!i_rst && !i_hold) begin
      if (i_r0_valid && i_r1_valid) begin
        w_gnt0 = r_last;
        w_gnt1 = !r_last;
      end else begin
        w_gnt0 = i_r0_valid;
        w_gnt1 = i_r1_valid;
      end
    end
  end

  assign w_xfer     = w_gnt0 | w_gnt1;
  assign o_r0_ready = w_gnt0;
  assign o_r1_ready = w_gnt1;

  // Priority pointer follows the last transfer; reset makes requester 0 win first contention.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= 1'b1;
    end else if (w_xfer) begin
      r_last <= w_gnt1;
    end
  end

  // Operand register: winner's operands on a transfer, zeros otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mul_a <= 32'h0;
      r_mul_b <= 32'h0;
    end else if (w_gnt0) begin
      r_mul_a <= i_r0_a;
      r_mul_b <= i_r0_b;
    end else if (w_gnt1) begin
      r_mul_a <= i_r1_a;
      r_mul_b <= i_r1_b;
    end else begin
      r_mul_a <= 32'h0;
      r_mul_b <= 32'h0;
    end
  end

  // Tag pipeline shadows the multiplier; the id bit is forced to 0 for empty slots.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tag_vld <= '0;
      r_tag_id  <= '0;
    end else begin
      r_tag_vld <= {r_tag_vld[DEPTH-2:0], w_xfer};
      r_tag_id  <= {r_tag_id[DEPTH-2:0], w_gnt1};
    end
  end

  // In-flight count: +1 per grant, -1 per delivered result, unchanged when both coincide.
  always_comb begin
    w_inflight_nxt = r_inflight;
    case ({w_xfer, r_tag_vld[DEPTH-1]})
      2'b10:   w_inflight_nxt = r_inflight + 4'd1;
      2'b01:   w_inflight_nxt = r_inflight - 4'd1;
      default: w_inflight_nxt = r_inflight;
    endcase
  end

  // Registered count and idle flag, both derived from the same next value so they never disagree.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_inflight <= 4'd0;
      r_idle     <= 1'b1;
    end else begin
      r_inflight <= w_inflight_nxt;
      r_idle     <= (w_inflight_nxt == 4'd0);
    end
  end

  assign o_mul_a     = r_mul_a;
  assign o_mul_b     = r_mul_b;
  assign o_res_valid = r_tag_vld[DEPTH-1];
  assign o_res_id    = r_tag_id[DEPTH-1];
  assign o_res_z     = i_mul_z;
  assign o_inflight  = r_inflight;
  assign o_idle      = r_idle;

  // Grants are mutually exclusive and the count never exceeds the pipeline depth.
  a_one_grant: assert property (@(posedge i_clk) !(o_r0_ready && o_r1_ready));
  a_inflight_max: assert property (@(posedge i_clk) disable iff (i_rst) o_inflight <= 4'(DEPTH));

endmodule
